// File: rtl/axi4_lite_write_master_q.sv
// Queued AXI4-Lite write master: DEPTH-entry command FIFO feeding one outstanding AW/W/B transaction.
// Optional sticky error capture (err_valid/err_addr/err_clear) is built when AXIW_ERR_CAPTURE_EN is defined.
module axi4_lite_write_master_q #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [1:0]            resp_code,
    output logic                  err_valid,
    output logic [ADDR_WIDTH-1:0] err_addr,
    input  logic                  err_clear,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [STRB_WIDTH-1:0] strb_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    logic       resp_valid_q;
    logic [1:0] resp_code_q;

    logic not_full;
    logic push;
    logic pop;
    logic bready;
    logic b_hs;

    // Readiness is based on the registered level only, so a pop in the same cycle never frees a slot.
    assign not_full = (level_q < LVL_W'(DEPTH));
    assign push     = cmd_valid && not_full;
    assign b_hs     = bready && M_AXI_BVALID;

    // ---------------- command FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= cmd_addr;
            data_mem_q[wr_ptr_q] <= cmd_data;
            strb_mem_q[wr_ptr_q] <= cmd_strb;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ---------------- transaction FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                if (!awvalid_d && !wvalid_d) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        bready = 1'b0;
        case (state_q)
            S_IDLE:  pop    = (level_q != '0);
            S_RESP:  bready = 1'b1;
            default: ;
        endcase
    end

    // ---------------- AW/W channel registers ----------------
    // Each VALID drops independently after its own handshake; payload only changes on a pop.
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (pop) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_mem_q[rd_ptr_q];
            wdata_d   = data_mem_q[rd_ptr_q];
            wstrb_d   = strb_mem_q[rd_ptr_q];
        end else begin
            if (awvalid_q && M_AXI_AWREADY) begin
                awvalid_d = 1'b0;
            end
            if (wvalid_q && M_AXI_WREADY) begin
                wvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // ---------------- response return ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
        end else begin
            resp_valid_q <= b_hs;
            if (b_hs) begin
                resp_code_q <= M_AXI_BRESP;
            end
        end
    end

`ifdef AXIW_ERR_CAPTURE_EN
    logic                  err_valid_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // First SLVERR/DECERR wins; a same-cycle clear takes priority over a new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_clear) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (b_hs && M_AXI_BRESP[1] && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= awaddr_q;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign err_valid        = 1'b0;
    assign err_addr         = '0;
`endif

    assign cmd_ready     = rst_n && not_full;
    assign fifo_level    = level_q;
    assign busy          = (level_q != '0) || (state_q != S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_code     = resp_code_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready;

endmodule
